// File: rtl/mips_dbg_pkg.sv
// Shared encodings for the MIPS debug run/step sequencer: command codes and FSM state codes.
package mips_dbg_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [1:0] {
        CMD_NOP  = 2'b00,
        CMD_RUN  = 2'b01,
        CMD_STEP = 2'b10,
        CMD_STOP = 2'b11
    } cmd_e;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } state_e;

endpackage

// File: rtl/pipeline_step_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_count
);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_count <= '0;
        end else if (i_clr) begin
            o_count <= '0;
        end else if (i_inc && (o_count != {WIDTH{1'b1}})) begin
            o_count <= o_count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipeline_step_ctrl.sv
// Run/step sequencer driving MIPS pipeline-register enables and flushes.
// Optional macro STEP_BUDGET_EN adds i_budget, limiting a RUN to a number of stepped cycles.
module pipeline_step_ctrl
    import mips_dbg_pkg::*;
#(
    parameter int NBITS        = 32,
    parameter int DRAIN_CYCLES = 1
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_cmd_valid,
    input  logic [1:0]         i_cmd,
    output logic               o_cmd_ready,
    input  logic               i_HALT,
    input  logic               i_BranchTaken,
    input  logic               i_Stall,
`ifdef STEP_BUDGET_EN
    input  logic [NBITS-1:0]   i_budget,
`endif
    output logic               o_Step,
    output logic               o_PCWrite,
    output logic               o_IF_ID_Write,
    output logic               o_Flush_IF_ID,
    output logic               o_Flush_ID_EX,
    output logic               o_Flush_EX_MEM,
    output logic [STATE_W-1:0] o_state,
    output logic [NBITS-1:0]   o_cycles,
    output logic               o_done
);

    state_e     state, state_nxt;
    logic [2:0] drain_cnt, drain_nxt;
    cmd_e       cmd;
    logic       budget_last;

    assign cmd = cmd_e'(i_cmd);

`ifdef STEP_BUDGET_EN
    logic [NBITS-1:0] budget_reg;
    logic [NBITS-1:0] budget_used;
    logic             run_accept;

    assign run_accept = (state == ST_IDLE) && i_cmd_valid && (cmd == CMD_RUN);

    // A zero budget means the RUN is unlimited.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            budget_reg <= '0;
        end else if (run_accept) begin
            budget_reg <= i_budget;
        end
    end

    sat_counter #(.WIDTH(NBITS)) u_budget (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_inc   (state == ST_RUN),
        .i_clr   (run_accept),
        .o_count (budget_used)
    );

    assign budget_last = (budget_reg != '0) && (budget_used == budget_reg - NBITS'(1));
`else
    assign budget_last = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state     <= ST_IDLE;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        drain_nxt      = drain_cnt;
        o_cmd_ready    = 1'b0;
        o_Step         = 1'b0;
        o_PCWrite      = 1'b0;
        o_IF_ID_Write  = 1'b0;
        o_Flush_IF_ID  = 1'b0;
        o_Flush_ID_EX  = 1'b0;
        o_Flush_EX_MEM = 1'b0;
        case (state)
            ST_IDLE: begin
                o_cmd_ready = 1'b1;
                if (i_cmd_valid) begin
                    if (cmd == CMD_RUN) begin
                        state_nxt = ST_RUN;
                    end else if (cmd == CMD_STEP) begin
                        state_nxt = ST_STEP;
                    end
                end
            end
            ST_RUN, ST_STEP: begin
                o_Step      = 1'b1;
                o_cmd_ready = (state == ST_RUN) && (cmd == CMD_STOP);
                // Branch beats stall: the wrong-path instructions are flushed anyway.
                if (i_BranchTaken) begin
                    o_PCWrite      = 1'b1;
                    o_IF_ID_Write  = 1'b1;
                    o_Flush_IF_ID  = 1'b1;
                    o_Flush_ID_EX  = 1'b1;
                    o_Flush_EX_MEM = 1'b1;
                end else if (i_Stall) begin
                    o_Flush_ID_EX  = 1'b1;
                end else begin
                    o_PCWrite      = 1'b1;
                    o_IF_ID_Write  = 1'b1;
                end
                if (i_HALT) begin
                    state_nxt = ST_DRAIN;
                    drain_nxt = 3'(DRAIN_CYCLES);
                end else if (state == ST_STEP) begin
                    state_nxt = ST_IDLE;
                end else if (budget_last || (i_cmd_valid && (cmd == CMD_STOP))) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                o_Step         = 1'b1;
                o_Flush_IF_ID  = 1'b1;
                o_Flush_ID_EX  = 1'b1;
                o_Flush_EX_MEM = 1'b1;
                if (drain_cnt <= 3'd1) begin
                    state_nxt = ST_HALTED;
                    drain_nxt = '0;
                end else begin
                    drain_nxt = drain_cnt - 3'd1;
                end
            end
            ST_HALTED: begin
                state_nxt = ST_HALTED;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    sat_counter #(.WIDTH(NBITS)) u_cycles (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_inc   (o_Step),
        .i_clr   (1'b0),
        .o_count (o_cycles)
    );

    assign o_state = state;
    assign o_done  = (state == ST_HALTED);

endmodule

// File: tb/tb_pipeline_step_ctrl.sv
// Scoreboard bench for pipeline_step_ctrl: directed cycles push expected snapshots, a monitor compares.
// The budget scenario is compiled only when STEP_BUDGET_EN is defined.
module tb_pipeline_step_ctrl;
    import mips_dbg_pkg::*;

    localparam int NBITS = 32;

    logic             i_clk;
    logic             i_reset;
    logic             i_cmd_valid;
    logic [1:0]       i_cmd;
    logic             o_cmd_ready;
    logic             i_HALT;
    logic             i_BranchTaken;
    logic             i_Stall;
`ifdef STEP_BUDGET_EN
    logic [NBITS-1:0] i_budget;
`endif
    logic             o_Step;
    logic             o_PCWrite;
    logic             o_IF_ID_Write;
    logic             o_Flush_IF_ID;
    logic             o_Flush_ID_EX;
    logic             o_Flush_EX_MEM;
    logic [2:0]       o_state;
    logic [NBITS-1:0] o_cycles;
    logic             o_done;

    typedef struct packed {
        logic [2:0]       st;
        logic             step;
        logic             pcw;
        logic             ifid;
        logic             fi;
        logic             fe;
        logic             fm;
        logic             rdy;
        logic             done;
        logic [NBITS-1:0] cyc;
    } snap_t;

    snap_t expQ[$];
    string nameQ[$];
    snap_t act;
    int    total = 0;
    int    bad = 0;
    int    expCycles = 0;
    event  sampleNow;

    pipeline_step_ctrl #(.NBITS(NBITS), .DRAIN_CYCLES(1)) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_cmd_valid    (i_cmd_valid),
        .i_cmd          (i_cmd),
        .o_cmd_ready    (o_cmd_ready),
        .i_HALT         (i_HALT),
        .i_BranchTaken  (i_BranchTaken),
        .i_Stall        (i_Stall),
`ifdef STEP_BUDGET_EN
        .i_budget       (i_budget),
`endif
        .o_Step         (o_Step),
        .o_PCWrite      (o_PCWrite),
        .o_IF_ID_Write  (o_IF_ID_Write),
        .o_Flush_IF_ID  (o_Flush_IF_ID),
        .o_Flush_ID_EX  (o_Flush_ID_EX),
        .o_Flush_EX_MEM (o_Flush_EX_MEM),
        .o_state        (o_state),
        .o_cycles       (o_cycles),
        .o_done         (o_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    assign act = {o_state, o_Step, o_PCWrite, o_IF_ID_Write, o_Flush_IF_ID,
                  o_Flush_ID_EX, o_Flush_EX_MEM, o_cmd_ready, o_done, o_cycles};

    // Monitor: drains the scoreboard on every falling edge or on an explicit mid-cycle sample.
    initial begin
        snap_t e;
        string n;
        forever begin
            @(negedge i_clk or sampleNow);
            while (expQ.size() > 0) begin
                e = expQ.pop_front();
                n = nameQ.pop_front();
                total++;
                if (act !== e) begin
                    bad++;
                    $display("[TB] FAIL %s: got st=%0d step=%b pcw=%b ifid=%b fl=%b%b%b rdy=%b done=%b cyc=%0d, need st=%0d step=%b pcw=%b ifid=%b fl=%b%b%b rdy=%b done=%b cyc=%0d",
                             n, act.st, act.step, act.pcw, act.ifid, act.fi, act.fe, act.fm, act.rdy, act.done, act.cyc,
                             e.st, e.step, e.pcw, e.ifid, e.fi, e.fe, e.fm, e.rdy, e.done, e.cyc);
                end
            end
        end
    end

    task automatic applyStimulus(input logic v, input logic [1:0] c, input logic h,
                                 input logic b, input logic s);
        @(posedge i_clk);
        #1;
        i_cmd_valid   = v;
        i_cmd         = c;
        i_HALT        = h;
        i_BranchTaken = b;
        i_Stall       = s;
    endtask

    // Pushes the expected snapshot; the cycle model advances when a stepped cycle is expected.
    task automatic checkOutput(input string name, input logic [2:0] st, input logic step,
                               input logic pcw, input logic ifid, input logic fi, input logic fe,
                               input logic fm, input logic rdy, input logic done);
        snap_t e;
        e = {st, step, pcw, ifid, fi, fe, fm, rdy, done, NBITS'(expCycles)};
        expQ.push_back(e);
        nameQ.push_back(name);
        if (step) expCycles++;
    endtask

    initial begin
        i_reset = 1'b1;
        i_cmd_valid = 1'b1;
        i_cmd = CMD_RUN;
        i_HALT = 1'b0;
        i_BranchTaken = 1'b0;
        i_Stall = 1'b0;
`ifdef STEP_BUDGET_EN
        i_budget = '0;
`endif
        @(posedge i_clk); #1;
        checkOutput("reset_hold", ST_IDLE, 0, 0, 0, 0, 0, 0, 1, 0);
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        checkOutput("reset_release", ST_IDLE, 0, 0, 0, 0, 0, 0, 1, 0);

        applyStimulus(0, CMD_NOP, 0, 0, 0);
        checkOutput("run_first", ST_RUN, 1, 1, 1, 0, 0, 0, 0, 0);
        for (int i = 1; i < 10; i++) begin
            applyStimulus(0, CMD_NOP, 0, 0, 0);
            checkOutput("run_steady", ST_RUN, 1, 1, 1, 0, 0, 0, 0, 0);
        end
        applyStimulus(0, CMD_NOP, 0, 0, 1);
        checkOutput("stall_bubble", ST_RUN, 1, 0, 0, 0, 1, 0, 0, 0);
        applyStimulus(0, CMD_NOP, 0, 1, 1);
        checkOutput("branch_over_stall", ST_RUN, 1, 1, 1, 1, 1, 1, 0, 0);
        applyStimulus(0, CMD_NOP, 0, 1, 0);
        checkOutput("branch_flush", ST_RUN, 1, 1, 1, 1, 1, 1, 0, 0);
        applyStimulus(1, CMD_RUN, 0, 0, 0);
        checkOutput("run_cmd_refused", ST_RUN, 1, 1, 1, 0, 0, 0, 0, 0);
        applyStimulus(1, CMD_STOP, 0, 0, 0);
        checkOutput("stop_accept", ST_RUN, 1, 1, 1, 0, 0, 0, 1, 0);
        applyStimulus(0, CMD_NOP, 0, 0, 1);
        checkOutput("idle_after_stop", ST_IDLE, 0, 0, 0, 0, 0, 0, 1, 0);

        applyStimulus(1, CMD_STEP, 0, 0, 0);
        checkOutput("step_cmd", ST_IDLE, 0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, CMD_NOP, 0, 0, 0);
        checkOutput("step_one", ST_STEP, 1, 1, 1, 0, 0, 0, 0, 0);
        applyStimulus(1, CMD_STEP, 0, 0, 0);
        checkOutput("step_back_idle", ST_IDLE, 0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, CMD_NOP, 0, 0, 0);
        checkOutput("step_two", ST_STEP, 1, 1, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, CMD_NOP, 0, 0, 0);
        checkOutput("step_done", ST_IDLE, 0, 0, 0, 0, 0, 0, 1, 0);

        applyStimulus(1, CMD_RUN, 0, 0, 0);
        checkOutput("halt_run_cmd", ST_IDLE, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 1; i < 5; i++) begin
            applyStimulus(0, CMD_NOP, 0, 0, 0);
            checkOutput("halt_pre_run", ST_RUN, 1, 1, 1, 0, 0, 0, 0, 0);
        end
        applyStimulus(0, CMD_NOP, 1, 0, 0);
        checkOutput("halt_seen", ST_RUN, 1, 1, 1, 0, 0, 0, 0, 0);
        applyStimulus(1, CMD_RUN, 0, 0, 0);
        checkOutput("drain", ST_DRAIN, 1, 0, 0, 1, 1, 1, 0, 0);
        applyStimulus(1, CMD_RUN, 0, 0, 0);
        checkOutput("halted_refuse", ST_HALTED, 0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, CMD_STEP, 0, 0, 0);
        checkOutput("halted_stays", ST_HALTED, 0, 0, 0, 0, 0, 0, 0, 1);

        @(posedge i_clk); #1;
        i_reset = 1'b1;
        expCycles = 0;
        checkOutput("reset_from_halted", ST_IDLE, 0, 0, 0, 0, 0, 0, 1, 0);
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        i_cmd_valid = 1'b1;
        i_cmd = CMD_RUN;
        checkOutput("rerun_cmd", ST_IDLE, 0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, CMD_NOP, 0, 0, 0);
        checkOutput("rerun", ST_RUN, 1, 1, 1, 0, 0, 0, 0, 0);
        applyStimulus(1, CMD_STOP, 1, 0, 0);
        checkOutput("stop_with_halt", ST_RUN, 1, 1, 1, 0, 0, 0, 1, 0);
        applyStimulus(0, CMD_NOP, 0, 0, 0);
        checkOutput("halt_beats_stop", ST_DRAIN, 1, 0, 0, 1, 1, 1, 0, 0);
        #5;
        i_reset = 1'b1;
        #1;
        expCycles = 0;
        checkOutput("async_reset_drain", ST_IDLE, 0, 0, 0, 0, 0, 0, 1, 0);
        ->sampleNow;

        @(posedge i_clk); #1;
        i_reset = 1'b0;
        i_cmd_valid = 1'b1;
        i_cmd = CMD_STEP;
        checkOutput("step_halt_cmd", ST_IDLE, 0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, CMD_NOP, 1, 1, 0);
        checkOutput("step_halt_branch", ST_STEP, 1, 1, 1, 1, 1, 1, 0, 0);
        applyStimulus(0, CMD_NOP, 0, 0, 0);
        checkOutput("step_halt_drain", ST_DRAIN, 1, 0, 0, 1, 1, 1, 0, 0);
        applyStimulus(0, CMD_NOP, 0, 0, 0);
        checkOutput("step_halt_halted", ST_HALTED, 0, 0, 0, 0, 0, 0, 0, 1);

`ifdef STEP_BUDGET_EN
        @(posedge i_clk); #1;
        i_reset = 1'b1;
        expCycles = 0;
        checkOutput("budget_reset", ST_IDLE, 0, 0, 0, 0, 0, 0, 1, 0);
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        i_cmd_valid = 1'b1;
        i_cmd = CMD_RUN;
        i_budget = 3;
        checkOutput("budget_cmd", ST_IDLE, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, CMD_NOP, 0, 0, 0);
            checkOutput("budget_run", ST_RUN, 1, 1, 1, 0, 0, 0, 0, 0);
        end
        applyStimulus(0, CMD_NOP, 0, 0, 0);
        checkOutput("budget_expired", ST_IDLE, 0, 0, 0, 0, 0, 0, 1, 0);
        i_budget = '0;
`endif

        @(posedge i_clk);
        @(negedge i_clk);
        #1;
        if (expQ.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending entries, need 0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
